// File: rtl/instr_rom_loader.sv
// Instruction ROM loader: packs a byte stream little-endian into
// the flat image read by fetch and publishes the word-rounded size.
module instr_rom_loader #(
  parameter int ROM_BYTES = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [ROM_BYTES*8-1:0] instr_rom,
  output logic [31:0]            rom_size,
  output logic                   load_done,
  output logic                   busy,
  output logic                   overflow
);

  localparam int AW = $clog2(ROM_BYTES);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE,
    ERROR
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0]              count;
  logic [ROM_BYTES-1:0][7:0]  mem;
  logic                       full;
  logic                       xfer;
  logic                       clear;
  logic [31:0]                size_nxt;

  assign full  = (count == CW'(ROM_BYTES));
  assign xfer  = (state == LOAD) && in_valid;
  assign clear = (state != LOAD) && start;

  // (count+1) rounded up to a word: (count+1+3) & ~3
  assign size_nxt = (32'(count) + 32'd4) & ~32'd3;

  assign instr_rom = mem;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    load_done = 1'b0;
    overflow  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          if (full)         state_nxt = ERROR;
          else if (in_last) state_nxt = DONE;
        end
      end
      DONE: begin
        load_done = 1'b1;
        if (start) state_nxt = LOAD;
      end
      ERROR: begin
        overflow = 1'b1;
        if (start) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Image, byte count and published size
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem      <= '0;
      count    <= '0;
      rom_size <= '0;
    end else if (clear) begin
      mem      <= '0;
      count    <= '0;
      rom_size <= '0;
    end else if (xfer && !full) begin
      mem[count[AW-1:0]] <= in_data;
      count              <= count + CW'(1);
      if (in_last) rom_size <= size_nxt;
    end
  end

endmodule

// File: tb/tb_instr_rom_loader.sv
// Directed self-checking bench for instr_rom_loader.
// Inputs change on negedge; outputs are sampled on negedge.
module tb_instr_rom_loader;

  localparam int RB = 1024;

  logic            clk;
  logic            reset;
  logic            start;
  logic            in_valid;
  logic [7:0]      in_data;
  logic            in_last;
  logic            in_ready;
  logic [RB*8-1:0] instr_rom;
  logic [31:0]     rom_size;
  logic            load_done;
  logic            busy;
  logic            overflow;

  int n_pass = 0;
  int n_tot  = 0;

  instr_rom_loader #(.ROM_BYTES(RB)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .instr_rom (instr_rom),
    .rom_size  (rom_size),
    .load_done (load_done),
    .busy      (busy),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    repeat (2) @(negedge clk);
    n_tot++;
    if ({in_ready, load_done, busy, overflow} !== 4'b0000 ||
        rom_size !== 32'd0 || instr_rom !== '0)
      $display("FAIL reset_state: rdy=%b done=%b busy=%b ovf=%b size=%0d rom_nz=%b want all 0",
               in_ready, load_done, busy, overflow, rom_size, |instr_rom);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_tot++;
    if (in_ready !== 1'b0 || busy !== 1'b0)
      $display("FAIL idle_after_reset: rdy=%b busy=%b want 0 0", in_ready, busy);
    else n_pass++;
  endtask

  task automatic test_basic();
    pulse_start();
    n_tot++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || rom_size !== 32'd0)
      $display("FAIL basic_loading: busy=%b rdy=%b size=%0d want 1 1 0",
               busy, in_ready, rom_size);
    else n_pass++;
    push(8'h13, 1'b0);
    push(8'h00, 1'b0);
    push(8'h50, 1'b0);
    push(8'h00, 1'b1);
    n_tot++;
    if (load_done !== 1'b1 || busy !== 1'b0 || rom_size !== 32'd4 ||
        instr_rom[31:0] !== 32'h00500013)
      $display("FAIL basic_done: done=%b busy=%b size=%0d w0=%h want 1 0 4 00500013",
               load_done, busy, rom_size, instr_rom[31:0]);
    else n_pass++;
  endtask

  task automatic test_gaps();
    pulse_start();
    for (int i = 1; i <= 5; i++) begin
      push(8'(i), i == 5);
      if (i < 5) begin
        in_data = 8'hFF;
        for (int g = 0; g < 2; g++) begin
          @(negedge clk);
          n_tot++;
          if (busy !== 1'b1 || rom_size !== 32'd0 || load_done !== 1'b0)
            $display("FAIL gap_wait: byte=%0d busy=%b size=%0d done=%b want 1 0 0",
                     i, busy, rom_size, load_done);
          else n_pass++;
        end
      end
    end
    n_tot++;
    if (load_done !== 1'b1 || rom_size !== 32'd8 ||
        instr_rom[63:0] !== 64'h00000005_04030201 || instr_rom[127:64] !== '0)
      $display("FAIL gap_done: done=%b size=%0d lo=%h want 1 8 0000000504030201",
               load_done, rom_size, instr_rom[63:0]);
    else n_pass++;
  endtask

  task automatic test_full();
    logic [7:0] b;
    pulse_start();
    for (int i = 0; i < RB; i++) begin
      b = 8'(i) ^ 8'h5A;
      push(b, i == RB - 1);
    end
    n_tot++;
    if (load_done !== 1'b1 || overflow !== 1'b0 || rom_size !== 32'd1024)
      $display("FAIL full_done: done=%b ovf=%b size=%0d want 1 0 1024",
               load_done, overflow, rom_size);
    else n_pass++;
    n_tot++;
    if (instr_rom[RB*8-1 -: 8] !== 8'hA5 || instr_rom[7:0] !== 8'h5A ||
        instr_rom[511*8 +: 8] !== 8'hA5)
      $display("FAIL full_bytes: b1023=%h b0=%h b511=%h want a5 5a a5",
               instr_rom[RB*8-1 -: 8], instr_rom[7:0], instr_rom[511*8 +: 8]);
    else n_pass++;
    pulse_start();
    push(8'hB7, 1'b0);
    push(8'h02, 1'b0);
    push(8'h00, 1'b0);
    push(8'h00, 1'b1);
    n_tot++;
    if (rom_size !== 32'd4 || instr_rom[RB*8-1:32] !== '0 ||
        instr_rom[31:0] !== 32'h000002B7)
      $display("FAIL reload_clear: size=%0d hi_nz=%b w0=%h want 4 0 000002b7",
               rom_size, |instr_rom[RB*8-1:32], instr_rom[31:0]);
    else n_pass++;
  endtask

  task automatic test_overflow();
    pulse_start();
    for (int i = 0; i < RB; i++) push(8'(i), 1'b0);
    n_tot++;
    if (busy !== 1'b1 || overflow !== 1'b0 || rom_size !== 32'd0)
      $display("FAIL ovf_at_cap: busy=%b ovf=%b size=%0d want 1 0 0",
               busy, overflow, rom_size);
    else n_pass++;
    push(8'hCC, 1'b0);
    n_tot++;
    if (overflow !== 1'b1 || rom_size !== 32'd0 || in_ready !== 1'b0 ||
        busy !== 1'b0 || load_done !== 1'b0)
      $display("FAIL ovf_flag: ovf=%b size=%0d rdy=%b busy=%b done=%b want 1 0 0 0 0",
               overflow, rom_size, in_ready, busy, load_done);
    else n_pass++;
    pulse_start();
    push(8'h6F, 1'b0);
    push(8'h00, 1'b0);
    push(8'h00, 1'b0);
    push(8'h00, 1'b1);
    n_tot++;
    if (load_done !== 1'b1 || overflow !== 1'b0 || rom_size !== 32'd4 ||
        instr_rom[31:0] !== 32'h0000006F)
      $display("FAIL ovf_recover: done=%b ovf=%b size=%0d w0=%h want 1 0 4 0000006f",
               load_done, overflow, rom_size, instr_rom[31:0]);
    else n_pass++;
  endtask

  task automatic test_start_in_load();
    pulse_start();
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    push(8'h33, 1'b0);
    start = 1'b1;
    push(8'h44, 1'b0);
    start = 1'b0;
    push(8'h55, 1'b0);
    push(8'h66, 1'b1);
    n_tot++;
    if (load_done !== 1'b1 || rom_size !== 32'd8 ||
        instr_rom[63:0] !== 64'h00006655_44332211)
      $display("FAIL start_in_load: done=%b size=%0d lo=%h want 1 8 0000665544332211",
               load_done, rom_size, instr_rom[63:0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    pulse_start();
    for (int i = 0; i < 6; i++) push(8'hA0 + 8'(i), 1'b0);
    #2 reset = 1'b0;
    #1;
    n_tot++;
    if (rom_size !== 32'd0 || instr_rom !== '0 || busy !== 1'b0 ||
        load_done !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL async_reset: size=%0d rom_nz=%b busy=%b done=%b rdy=%b want all 0",
               rom_size, |instr_rom, busy, load_done, in_ready);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_start_in_done();
    pulse_start();
    push(8'h01, 1'b0);
    push(8'h02, 1'b0);
    push(8'h03, 1'b0);
    push(8'h04, 1'b1);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    in_last  = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    n_tot++;
    if (load_done !== 1'b0 || rom_size !== 32'd0 || busy !== 1'b1 ||
        instr_rom[31:0] !== 32'd0)
      $display("FAIL start_in_done: done=%b size=%0d busy=%b w0=%h want 0 0 1 00000000",
               load_done, rom_size, busy, instr_rom[31:0]);
    else n_pass++;
    push(8'h93, 1'b0);
    push(8'h80, 1'b0);
    push(8'h10, 1'b0);
    push(8'h00, 1'b1);
    n_tot++;
    if (load_done !== 1'b1 || rom_size !== 32'd4 ||
        instr_rom[31:0] !== 32'h00108093)
      $display("FAIL done_reload: done=%b size=%0d w0=%h want 1 4 00108093",
               load_done, rom_size, instr_rom[31:0]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_full();
    test_overflow();
    test_start_in_load();
    test_reset_mid();
    test_start_in_done();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
